rr_bus_mux: RTL and testbench
=============================

// Module: rr_bus_mux
// PURPOSE
//  Registered N-channel bus multiplexer with arbitration, the parametrised successor to the
//  4:1 combinational select mux. Each source presents a WIDTH-bit word with a valid/ready
//  handshake. The block picks one source per transfer and registers its word onto a single
//  output channel with its own valid/ready. Sits between register-file/ALU sources and the
//  shared internal data bus.
// PARAMETERS
//  WIDTH     8  data word width in bits (>=1)
//  CHANNELS  4  number of input sources (>=2)
//  MODE      0  arbitration: 0 = round-robin, 1 = fixed priority (channel 0 highest)
//  SEL_W     localparam = $clog2(CHANNELS), channel index width
// PORTS
//  clk        in   1                 clock, all state on rising edge
//  rst        in   1                 synchronous reset, active-high
//  in_data    in   CHANNELS*WIDTH    channel i word at [i*WIDTH +: WIDTH]
//  in_valid   in   CHANNELS          channel i word available
//  in_ready   out  CHANNELS          channel i word taken this cycle (one-hot or zero)
//  force_en   in   1                 manual select: only channel force_sel may be granted
//  force_sel  in   SEL_W             manual channel index (values >= CHANNELS grant nothing)
//  out_data   out  WIDTH             registered selected word
//  out_sel    out  SEL_W             index of the channel that supplied out_data
//  out_valid  out  1                 out_data/out_sel valid
//  out_ready  in   1                 downstream accepts word when out_valid & out_ready
// BEHAVIOUR
//  - Reset (sync, rst=1 at clk edge): out_valid=0, out_data=0, out_sel=0, RR pointer=0;
//    in_ready all 0 while rst=1. Word held at reset is discarded.
//  - Output register states: EMPTY (out_valid=0), FULL (out_valid=1).
//  - load_en = ~out_valid | out_ready (combinational). Register loads only when load_en.
//  - Candidates: force_en ? (in_valid & onehot(force_sel)) : in_valid.
//  - Grant (combinational, one-hot): MODE 0 -> first candidate scanning from RR pointer
//    upward with wrap at CHANNELS-1 -> 0; MODE 1 -> lowest-index candidate.
//  - in_ready[i] = load_en & grant[i]; never depends on in_valid of other cycles.
//    Transfer on channel i = in_valid[i] & in_ready[i].
//  - On transfer: out_data <= word i, out_sel <= i, out_valid <= 1. Latency 1 clock.
//  - FULL, out_ready=1, no candidate: out_valid <= 0 (-> EMPTY); out_data/out_sel hold.
//  - FULL, out_ready=0: everything holds, in_ready all 0 (back-pressure).
//  - Simultaneous accept + new transfer: word replaced same edge, out_valid stays 1
//    (full throughput, one word per clock).
//  - RR pointer (MODE 0 only) <= (i+1) mod CHANNELS after transfer on i; unchanged
//    otherwise, including during force_en. MODE 1 ignores pointer.
//  - force_en/force_sel changes while FULL do not alter the held word.
//  - Sources must hold in_data stable while in_valid=1 and in_ready=0.
//  - Only WIDTH bits of each lane are used; no arithmetic, no truncation.
// TESTING (WIDTH=8, CHANNELS=4 unless stated; in_data lanes 0..3 = 00,AA,FF,55)
//  1 rst=1 two clocks, all in_valid=1 -> out_valid=0, out_data=00, in_ready=0000.
//  2 MODE0, all in_valid=1, out_ready=1 for 8 clocks -> out_sel 0,1,2,3,0,1,2,3;
//    out_data 00,AA,FF,55 repeating; out_valid=1 every clock after first.
//  3 MODE1, all valid, out_ready=1 -> out_sel stays 0, out_data=00; drop in_valid[0]
//    -> out_sel=1, out_data=AA next clock.
//  4 FULL with AA, out_ready=0 for 5 clocks -> out_data=AA, in_ready=0000 throughout;
//    raise out_ready -> next word loads same edge, no bubble.
//  5 force_en=1, force_sel=2, all valid -> out_sel=2, out_data=FF only; force_sel=3
//    -> 55; CHANNELS=3 build with force_sel=3 -> out_valid falls to 0.
//  6 Mid-stream rst with out_valid=1 -> next clock out_valid=0, then MODE0 restarts at
//    channel 0; random valid/ready soak checks no word lost or duplicated vs model.

Source files
------------

// File: rtl/rr_bus_if.sv
// rr_bus_if: bundle of the source-side and sink-side handshake signals of
// rr_bus_mux.
//   in_data   CHANNELS*WIDTH  source words, lane i at [i*WIDTH +: WIDTH]
//   in_valid  CHANNELS        per-source word available
//   in_ready  CHANNELS        per-source word taken this cycle (one-hot or zero)
//   force_en  1               restrict grant to channel force_sel
//   force_sel SEL_W           manual channel index (>= CHANNELS grants nothing)
//   out_data  WIDTH           registered selected word
//   out_sel   SEL_W           channel that supplied out_data
//   out_valid 1               out_data/out_sel valid
//   out_ready 1               sink accepts when out_valid & out_ready
// modport slave is the mux side, modport master is the sources/sink side.
interface rr_bus_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      force_en;
    logic [SEL_W-1:0]          force_sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in_data, in_valid, force_en, force_sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, force_en, force_sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_bus_mux.sv
// rr_bus_mux: registered N-channel bus multiplexer with arbitration.
// One source word per transfer is selected (round-robin or fixed priority,
// optionally restricted to a forced channel) and registered onto a single
// valid/ready output channel. Full throughput: a word can be accepted and
// replaced on the same edge.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous reset, active-high
//   bus  - rr_bus_if.slave (source words/handshake in, output channel out)
// Parameters: WIDTH word width, CHANNELS source count (>=2),
//   MODE 0 = round-robin, 1 = fixed priority (channel 0 highest).
module rr_bus_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0
) (
    input  logic    clk,
    input  logic    rst,
    rr_bus_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_p1;
    state_t              state_nxt;
    logic [WIDTH-1:0]    data_p1;
    logic [SEL_W-1:0]    sel_p1;
    logic [SEL_W-1:0]    rr_ptr;

    logic                load_en;
    logic [CHANNELS-1:0] force_mask;
    logic [CHANNELS-1:0] cand;
    logic [CHANNELS-1:0] grant;
    logic                found;
    logic [SEL_W-1:0]    gidx;
    logic [WIDTH-1:0]    gword;
    logic [WIDTH-1:0]    lanes [CHANNELS];

    assign load_en = (state_p1 == EMPTY) | bus.out_ready;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            lanes[i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // force_sel values beyond the last channel match no lane, so nothing is granted.
    always_comb begin
        force_mask = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.force_sel == SEL_W'(i)) begin
                force_mask[i] = 1'b1;
            end
        end
    end

    assign cand = bus.force_en ? (bus.in_valid & force_mask) : bus.in_valid;

    // Scan CHANNELS positions starting at rr_ptr (MODE 0) or at 0 (MODE 1),
    // wrapping past the last channel; first candidate seen wins.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] sidx;
        grant = '0;
        found = 1'b0;
        gidx  = '0;
        gword = '0;
        idx   = 0;
        sidx  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = (MODE == 1) ? k : int'(rr_ptr) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            sidx = SEL_W'(idx);
            if (!found && cand[sidx]) begin
                found       = 1'b1;
                grant[sidx] = 1'b1;
                gidx        = sidx;
                gword       = lanes[sidx];
            end
        end
    end

    // Grant is only offered while the output register can load; held low in reset.
    assign bus.in_ready = (rst || !load_en) ? '0 : grant;

    always_comb begin
        state_nxt = state_p1;
        if (load_en) begin
            state_nxt = found ? FULL : EMPTY;
        end
    end

    // ---- stage p1: output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= EMPTY;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
            sel_p1  <= '0;
            rr_ptr  <= '0;
        end else if (load_en && found) begin
            data_p1 <= gword;
            sel_p1  <= gidx;
            // Forced transfers leave the rotation where it was.
            if (MODE == 0 && !bus.force_en) begin
                rr_ptr <= (gidx == SEL_W'(CHANNELS - 1)) ? '0 : gidx + SEL_W'(1);
            end
        end
    end

    assign bus.out_valid = (state_p1 == FULL);
    assign bus.out_data  = data_p1;
    assign bus.out_sel   = sel_p1;
endmodule

// File: tb/tb_rr_bus_mux.sv
module tb_rr_bus_mux;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic        force_en;
    logic [1:0]  force_sel;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_bus_if #(.WIDTH(8), .CHANNELS(4)) bus_rr ();
    rr_bus_if #(.WIDTH(8), .CHANNELS(4)) bus_fp ();
    rr_bus_if #(.WIDTH(8), .CHANNELS(3)) bus_c3 ();

    assign bus_rr.in_data   = in_data;
    assign bus_rr.in_valid  = in_valid;
    assign bus_rr.force_en  = force_en;
    assign bus_rr.force_sel = force_sel;
    assign bus_rr.out_ready = out_ready;
    assign bus_fp.in_data   = in_data;
    assign bus_fp.in_valid  = in_valid;
    assign bus_fp.force_en  = force_en;
    assign bus_fp.force_sel = force_sel;
    assign bus_fp.out_ready = out_ready;
    assign bus_c3.in_data   = in_data[23:0];
    assign bus_c3.in_valid  = in_valid[2:0];
    assign bus_c3.force_en  = force_en;
    assign bus_c3.force_sel = force_sel;
    assign bus_c3.out_ready = out_ready;

    rr_bus_mux #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_rr (.clk(clk), .rst(rst), .bus(bus_rr));
    rr_bus_mux #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_fp (.clk(clk), .rst(rst), .bus(bus_fp));
    rr_bus_mux #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u_c3 (.clk(clk), .rst(rst), .bus(bus_c3));

    typedef struct {
        logic [3:0] valid;
        logic       ordy;
        logic       fe;
        logic [1:0] fs;
        logic [3:0] rdy;
        logic       vld;
        logic [1:0] sel;
        logic [7:0] data;
    } vec_t;

    localparam logic [31:0] LANES = {8'h55, 8'hFF, 8'hAA, 8'h00};

    vec_t tbl [26];

    function automatic vec_t mk(logic [3:0] v, logic o, logic fe, logic [1:0] fs,
                                logic [3:0] r, logic vl, logic [1:0] s, logic [7:0] d);
        vec_t t;
        t.valid = v; t.ordy = o; t.fe = fe; t.fs = fs;
        t.rdy = r; t.vld = vl; t.sel = s; t.data = d;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic soak(int n);
        int         m_vld, m_sel, m_ptr, g, idx;
        logic [7:0] m_data;
        logic [7:0] d [4];
        logic [3:0] v;
        logic [3:0] exp_rdy;
        logic [3:0] pend;
        // state after the restart transfer from channel 0
        m_vld = 1; m_sel = 0; m_ptr = 1; m_data = 8'h00;
        pend = '0;
        v = '0;
        for (int i = 0; i < 4; i++) d[i] = 8'h00;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    d[i] = 8'($urandom);
                end
            end
            in_valid  = v;
            in_data   = {d[3], d[2], d[1], d[0]};
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (m_vld == 0 || out_ready) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (g < 0 && v[idx]) g = idx;
                end
            end
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
            chk("soak_in_ready", 32'(bus_rr.in_ready), 32'(exp_rdy));
            tick();
            if (m_vld == 0 || out_ready) begin
                if (g >= 0) begin
                    m_vld = 1; m_data = d[g]; m_sel = g; m_ptr = (g + 1) % 4;
                end else begin
                    m_vld = 0;
                end
            end
            for (int i = 0; i < 4; i++) pend[i] = v[i] && (g != i);
            chk("soak_out_valid", 32'(bus_rr.out_valid), 32'(m_vld));
            if (m_vld != 0) begin
                chk("soak_out_data", 32'(bus_rr.out_data), 32'(m_data));
                chk("soak_out_sel", 32'(bus_rr.out_sel), 32'(m_sel));
            end
        end
    endtask

    initial begin
        // v, ordy, fe, fs | exp in_ready (pre-edge), out_valid, out_sel, out_data (post-edge)
        tbl[0]  = mk(4'hF, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 8'h00);
        tbl[1]  = mk(4'hF, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 8'hAA);
        tbl[2]  = mk(4'hF, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 8'hFF);
        tbl[3]  = mk(4'hF, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 8'h55);
        tbl[4]  = mk(4'hF, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 8'h00);
        tbl[5]  = mk(4'hF, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 8'hAA);
        tbl[6]  = mk(4'hF, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 8'hFF);
        tbl[7]  = mk(4'hF, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 8'h55);
        tbl[8]  = mk(4'hF, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 8'h00);
        tbl[9]  = mk(4'hF, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 8'hAA);
        tbl[10] = mk(4'hF, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 8'hAA);
        tbl[11] = mk(4'hF, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 8'hAA);
        tbl[12] = mk(4'hF, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 8'hAA);
        tbl[13] = mk(4'hF, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 8'hAA);
        tbl[14] = mk(4'hF, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 8'hAA);
        tbl[15] = mk(4'hF, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 8'hFF);
        tbl[16] = mk(4'hF, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 2'd2, 8'hFF);
        tbl[17] = mk(4'hF, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 2'd2, 8'hFF);
        tbl[18] = mk(4'hF, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 2'd3, 8'h55);
        tbl[19] = mk(4'h7, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 2'd3, 8'h55);
        tbl[20] = mk(4'hF, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 8'h55);
        tbl[21] = mk(4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd3, 8'h55);
        tbl[22] = mk(4'h4, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 8'hFF);
        tbl[23] = mk(4'hF, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 2'd2, 8'hFF);
        tbl[24] = mk(4'hF, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 2'd0, 8'h00);
        tbl[25] = mk(4'hF, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 8'h55);

        // reset with all sources valid
        rst = 1'b1; in_data = LANES; in_valid = 4'hF;
        force_en = 1'b0; force_sel = 2'd0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready_comb", 32'(bus_rr.in_ready), 32'h0);
        tick();
        tick();
        chk("rst_out_valid", 32'(bus_rr.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus_rr.out_data), 32'h0);
        chk("rst_out_sel", 32'(bus_rr.out_sel), 32'h0);
        chk("rst_in_ready", 32'(bus_rr.in_ready), 32'h0);
        chk("rst_fp_out_valid", 32'(bus_fp.out_valid), 32'h0);
        rst = 1'b0;

        // round-robin rotation, back-pressure, forcing
        for (int i = 0; i < 26; i++) begin
            in_valid  = tbl[i].valid;
            out_ready = tbl[i].ordy;
            force_en  = tbl[i].fe;
            force_sel = tbl[i].fs;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(bus_rr.in_ready), 32'(tbl[i].rdy));
            tick();
            chk($sformatf("v%0d_out_valid", i), 32'(bus_rr.out_valid), 32'(tbl[i].vld));
            chk($sformatf("v%0d_out_sel", i), 32'(bus_rr.out_sel), 32'(tbl[i].sel));
            chk($sformatf("v%0d_out_data", i), 32'(bus_rr.out_data), 32'(tbl[i].data));
        end

        // 3-channel build: force_sel=2 selects lane 2, force_sel=3 selects nothing
        in_valid = 4'hF; out_ready = 1'b1; force_en = 1'b1; force_sel = 2'd2;
        #1;
        chk("c3_fs2_in_ready", 32'(bus_c3.in_ready), 32'b100);
        tick();
        chk("c3_fs2_out_sel", 32'(bus_c3.out_sel), 32'd2);
        chk("c3_fs2_out_data", 32'(bus_c3.out_data), 32'hFF);
        force_sel = 2'd3;
        #1;
        chk("c3_fs3_in_ready", 32'(bus_c3.in_ready), 32'b000);
        tick();
        chk("c3_fs3_out_valid", 32'(bus_c3.out_valid), 32'h0);
        chk("c3_fs3_out_data_hold", 32'(bus_c3.out_data), 32'hFF);
        chk("rr_fs3_out_data", 32'(bus_rr.out_data), 32'h55);

        // fixed priority: channel 0 wins while valid
        rst = 1'b1; force_en = 1'b0; force_sel = 2'd0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fp_hold%0d_sel", i), 32'(bus_fp.out_sel), 32'd0);
            chk($sformatf("fp_hold%0d_data", i), 32'(bus_fp.out_data), 32'h00);
            chk($sformatf("fp_hold%0d_valid", i), 32'(bus_fp.out_valid), 32'h1);
        end
        in_valid = 4'hE;
        #1;
        chk("fp_drop0_in_ready", 32'(bus_fp.in_ready), 32'b0010);
        tick();
        chk("fp_drop0_sel", 32'(bus_fp.out_sel), 32'd1);
        chk("fp_drop0_data", 32'(bus_fp.out_data), 32'hAA);

        // mid-stream reset while holding a word, then restart at channel 0
        in_valid = 4'hF;
        tick();
        chk("mid_pre_valid", 32'(bus_rr.out_valid), 32'h1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(bus_rr.out_valid), 32'h0);
        chk("mid_rst_data", 32'(bus_rr.out_data), 32'h0);
        rst = 1'b0;
        #1;
        chk("mid_restart_in_ready", 32'(bus_rr.in_ready), 32'b0001);
        tick();
        chk("mid_restart_sel", 32'(bus_rr.out_sel), 32'd0);
        chk("mid_restart_data", 32'(bus_rr.out_data), 32'h00);

        soak(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
